// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM states, frame/data width defaults and the
// 2-bit command codes carried in the top bits of every received frame.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises a command+payload frame from MOSI for the
// memory block, and serialises one byte of read data back on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam logic [3:0] RX_LAST = 4'(FRAME_W);
    localparam logic [3:0] TX_LAST = 4'(DATA_W);

    // Handshake: rx_valid is a single-cycle strobe; there is no back-pressure.
    // tx_valid is sampled only while tx_armed, i.e. after a READ_DATA frame's
    // rx_valid and before the first accepted tx_valid.
    state_e             state;
    logic [FRAME_W-1:0] shift_reg;
    logic [DATA_W-1:0]  tx_shift;
    logic [3:0]         rx_cnt;
    logic [3:0]         tx_cnt;
    logic               frame_done;
    logic               rd_addr_seen;
    logic               tx_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            tx_shift     <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_armed     <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Frame boundary: drop any partial frame, keep rd_addr_seen.
                state      <= IDLE;
                rx_cnt     <= '0;
                tx_cnt     <= '0;
                frame_done <= 1'b0;
                tx_armed   <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        shift_reg <= {{(FRAME_W-1){1'b0}}, MOSI};
                        rx_cnt    <= 4'd1;
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    default: begin
                        if (rx_cnt < RX_LAST) begin
                            shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
                            rx_cnt    <= rx_cnt + 4'd1;
                        end else if (!frame_done) begin
                            frame_done <= 1'b1;
                            rx_data    <= shift_reg;
                            rx_valid   <= 1'b1;
                            if (state == READ_ADD)
                                rd_addr_seen <= 1'b1;
                            if (state == READ_DATA) begin
                                rd_addr_seen <= 1'b0;
                                tx_armed     <= 1'b1;
                            end
                        end else if (tx_armed && tx_valid) begin
                            tx_armed <= 1'b0;
                            MISO     <= tx_data[DATA_W-1];
                            tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                            tx_cnt   <= 4'd1;
                        end else if (tx_cnt != 4'd0 && tx_cnt < TX_LAST) begin
                            MISO     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            tx_cnt   <= tx_cnt + 4'd1;
                        end else begin
                            MISO <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: stimulus tasks push expected frames and MISO
// bits into queues; a monitor pops and compares every cycle.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic [9:0] rx_exp_q[$];
    logic       miso_exp_q[$];
    int         total;
    int         bad;
    logic       prev_rxv;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // monitor / scoreboard
    initial prev_rxv = 1'b0;
    always begin
        logic exp_bit;
        logic [9:0] exp_rx;
        @(posedge clk);
        #1;
        exp_bit = 1'b0;
        if (miso_exp_q.size() > 0)
            exp_bit = miso_exp_q.pop_front();
        chk("miso", {31'b0, miso}, {31'b0, exp_bit});
        if (rx_valid) begin
            chk("rx_valid_width", {31'b0, prev_rxv}, 32'd0);
            if (rx_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got rx_data 0x%0h want no rx_valid at %0t", rx_data, $time);
            end else begin
                exp_rx = rx_exp_q.pop_front();
                chk("rx_data", {22'b0, rx_data}, {22'b0, exp_rx});
            end
        end
        prev_rxv = rx_valid;
    end

    // drivers
    task automatic send_frame(input logic [9:0] bits, input logic spur, input logic expect_rx);
        if (expect_rx)
            rx_exp_q.push_back(bits);
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            mosi = bits[i];
            tx_valid = spur && (i <= 5) && (i >= 3);
            tx_data = 8'hFF;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 7; i >= 0; i--)
            miso_exp_q.push_back(d[i]);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        #2;
        chk("reset_rx_data", {22'b0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("reset_miso", {31'b0, miso}, 32'd0);
        chk("reset_state", {29'b0, dut.state}, {29'b0, IDLE});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // write address then write data
        send_frame({CMD_WR_ADDR, 8'h05}, 1'b0, 1'b1);
        end_frame();
        send_frame({CMD_WR_DATA, 8'hAA}, 1'b0, 1'b1);
        end_frame();

        // read address then read data with 0xAA returned
        send_frame({CMD_RD_ADDR, 8'h05}, 1'b0, 1'b1);
        end_frame();
        chk("rd_addr_seen_set", {31'b0, dut.rd_addr_seen}, 32'd1);
        send_frame({CMD_RD_DATA, 8'hC5}, 1'b0, 1'b1);
        send_tx(8'hAA);
        repeat (10) @(negedge clk);
        chk("rd_addr_seen_clr", {31'b0, dut.rd_addr_seen}, 32'd0);
        end_frame();

        // abort after 5 bits, then a full frame
        @(negedge clk);
        ss_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'(i & 1);
            @(negedge clk);
        end
        ss_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", {29'b0, dut.state}, {29'b0, IDLE});
        send_frame({CMD_WR_DATA, 8'h55}, 1'b0, 1'b1);
        end_frame();

        // spurious tx_valid during and after a write frame
        send_frame({CMD_WR_ADDR, 8'h3C}, 1'b1, 1'b1);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        end_frame();

        // read data with no tx_valid: MISO stays low
        send_frame({CMD_RD_ADDR, 8'h11}, 1'b0, 1'b1);
        end_frame();
        send_frame({CMD_RD_DATA, 8'h00}, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        end_frame();

        // reset in the middle of a read shift-out
        send_frame({CMD_RD_ADDR, 8'h22}, 1'b0, 1'b1);
        end_frame();
        send_frame({CMD_RD_DATA, 8'h33}, 1'b0, 1'b1);
        send_tx(8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        miso_exp_q.delete();
        #1;
        chk("rst_mid_miso", {31'b0, miso}, 32'd0);
        chk("rst_mid_state", {29'b0, dut.state}, {29'b0, IDLE});
        chk("rst_mid_rd_seen", {31'b0, dut.rd_addr_seen}, 32'd0);
        chk("rst_mid_rx_data", {22'b0, rx_data}, 32'd0);
        ss_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // after reset a 1x frame is a read address again
        send_frame({CMD_RD_ADDR, 8'hFF}, 1'b0, 1'b1);
        end_frame();
        chk("post_rst_rd_seen", {31'b0, dut.rd_addr_seen}, 32'd1);
        send_frame({CMD_WR_ADDR, 8'hA5}, 1'b0, 1'b1);
        end_frame();
        repeat (4) @(negedge clk);
        chk("rx_data_hold", {22'b0, rx_data}, {22'b0, CMD_WR_ADDR, 8'hA5});
        chk("rx_queue_empty", rx_exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter FRAME_W, default 10, meaning receive frame width (2 command bits + 8 payload bits).
REQ-002 SHALL have parameter DATA_W, default 8, meaning read-data width returned to the master.
REQ-003 SHALL have port clk  input  1  system clock; every flop updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port SS_n  input  1  SPI slave select, active-low; frame boundary.
REQ-006 SHALL have port MOSI  input  1  serial data from master, MSB first, sampled at clk rising edge.
REQ-007 SHALL have port MISO  output  1  serial read data to master, MSB first, registered.
REQ-008 SHALL have port rx_data  output  FRAME_W  parallel frame to memory; bits [9:8] are the command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
REQ-009 SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port tx_data  input  DATA_W  read data from memory.
REQ-011 SHALL have port tx_valid  input  1  qualifies tx_data.

Function
REQ-012 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 SHALL move IDLE->CHK_CMD on the first edge with SS_n=0.
REQ-014 SHALL, in CHK_CMD, capture MOSI as frame bit 9 and move to WRITE if MOSI=0, READ_ADD if MOSI=1 and rd_addr_seen=0, READ_DATA if MOSI=1 and rd_addr_seen=1.
REQ-015 SHALL shift the remaining 9 MOSI bits (bit 8 down to bit 0) on the 9 following edges in WRITE/READ_ADD/READ_DATA.
REQ-016 SHALL update rx_data and pulse rx_valid high for exactly one cycle on the edge after bit 0 is captured; rx_data holds its value until the next completed frame.
REQ-017 SHALL set internal flag rd_addr_seen when a READ_ADD frame completes and clear it when a READ_DATA frame completes; WRITE frames leave it unchanged.
REQ-018 SHALL, after a READ_DATA frame's rx_valid, accept tx_data only on the first edge with tx_valid=1; tx_valid in any other state or phase is ignored.
REQ-019 SHALL drive MISO with tx_data[7], [6], ..., [0] on the 8 consecutive cycles following the accepting edge, then hold MISO=0.
REQ-020 SHALL hold MISO=0 whenever no read data is being shifted out.
REQ-021 SHALL, after frame completion in any state, ignore further MOSI bits until SS_n returns high.
REQ-022 SHALL move any state to IDLE on an edge with SS_n=1, clearing bit counters and MISO with no rx_valid issued; a partial frame is discarded and rd_addr_seen is unchanged.
REQ-023 SHALL use a 4-bit receive counter (0..10) and a 4-bit transmit counter (0..8), neither wrapping.
REQ-024 SHALL remain in READ_DATA with MISO=0 indefinitely if tx_valid never arrives, until SS_n=1.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_seen=0 and both counters 0.
REQ-026 SHALL, on reset assertion mid-frame, abandon the frame with no rx_valid on release; first frame after release starts fresh from IDLE.

Structure
REQ-027 SHALL take the state enumeration, FRAME_W/DATA_W defaults and the 2-bit command codes from shared package spi_pkg, which the memory block also uses.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 SHALL cover write-address: SS_n low, MOSI 00_0000_0101 -> one rx_valid with rx_data=0x005, MISO=0 throughout.
REQ-030 SHALL cover write-data: frame 01_1010_1010 -> rx_data=0x1AA, rx_valid exactly one cycle.
REQ-031 SHALL cover read sequence: frame 10_0000_0101 (rd_addr_seen->1), SS_n high, frame 11_xxxx_xxxx -> rx_data[9:8]=11, tx_valid with tx_data=0xAA one cycle later -> MISO 1,0,1,0,1,0,1,0 on next 8 cycles, rd_addr_seen=0.
REQ-032 SHALL cover abort: SS_n raised after 5 bits -> state IDLE next edge, no rx_valid, next full frame decoded correctly.
REQ-033 SHALL cover spurious tx_valid: tx_valid=1 during WRITE frame -> MISO stays 0.
REQ-034 SHALL cover reset mid-READ_DATA shift-out: rst_n low -> MISO=0, state IDLE, rd_addr_seen=0 immediately.
